// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage.
//  cond_e      : ARM condition codes as they appear in Instr[31:28]
//  FLAG_*      : bit positions of N, Z, C, V inside a {N,Z,C,V} vector
//  cond_check  : evaluates a condition code against a {N,Z,C,V} vector.
//                Returns 0 for NV; the top decides whether NV executes.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_check(input cond_e cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic result;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        result = 1'b0;
        case (cond)
            EQ:      result = z;
            NE:      result = ~z;
            CS:      result = c;
            CC:      result = ~c;
            MI:      result = n;
            PL:      result = ~n;
            VS:      result = v;
            VC:      result = ~v;
            HI:      result = c & ~z;
            LS:      result = ~c | z;
            GE:      result = (n == v);
            LT:      result = (n != v);
            GT:      result = ~z & (n == v);
            LE:      result = z | (n != v);
            AL:      result = 1'b1;
            default: result = 1'b0;  // NV: resolved by the caller
        endcase
        return result;
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural NZCV flag register with independent N/Z and C/V write enables.
// Ports:
//  clk      in   rising-edge clock
//  reset    in   synchronous, active-low; loads RESET_FLAGS
//  wrNZ     in   load N,Z from flagsIn
//  wrCV     in   load C,V from flagsIn
//  flagsIn  in   candidate {N,Z,C,V}
//  flags    out  current {N,Z,C,V}
module flag_reg
    import cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wrNZ,
    input  logic       wrCV,
    input  logic [3:0] flagsIn,
    output logic [3:0] flags
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags <= RESET_FLAGS;
        end else begin
            if (wrNZ) begin
                flags[FLAG_N] <= flagsIn[FLAG_N];
                flags[FLAG_Z] <= flagsIn[FLAG_Z];
            end
            if (wrCV) begin
                flags[FLAG_C] <= flagsIn[FLAG_C];
                flags[FLAG_V] <= flagsIn[FLAG_V];
            end
        end
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage following the control decoder.
// Evaluates Cond against the current flags, gates the decoder's write
// requests and registers them for one cycle; updates NZCV when the accepted
// instruction executes.
// Ports:
//  clk, reset          clock, synchronous active-low reset
//  valid_i             decoder output valid
//  stall_i             hold stage and flags (wins over flush_i)
//  flush_i             kill the instruction offered this cycle
//  Cond                Instr[31:28]
//  ALUFlags            {N,Z,C,V} from the ALU for this instruction
//  FlagW               [1] writes N,Z; [0] writes C,V
//  PCS, RegW, MemW     decoder write requests
//  valid_o             stage holds a live instruction
//  CondEx              registered condition result
//  PCSrc/RegWrite/MemWrite  committed enables
//  Flags               current {N,Z,C,V}
module cond_unit
    import cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter bit         ALLOW_NV    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       valid_o,
    output logic       CondEx,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags
);

    logic  accept;
    logic  condExC;
    cond_e condCode;

    assign accept   = valid_i & ~stall_i & ~flush_i;
    assign condCode = cond_e'(Cond);

    // Evaluated against the flags before this instruction's own update, so a
    // back-to-back successor sees the predecessor's result without a bubble.
    always_comb begin
        condExC = 1'b0;
        if (condCode == NV) begin
            condExC = ALLOW_NV;
        end else begin
            condExC = cond_check(condCode, Flags);
        end
    end

    flag_reg #(
        .RESET_FLAGS(RESET_FLAGS)
    ) uFlagReg (
        .clk    (clk),
        .reset  (reset),
        .wrNZ   (accept & condExC & FlagW[1]),
        .wrCV   (accept & condExC & FlagW[0]),
        .flagsIn(ALUFlags),
        .flags  (Flags)
    );

    // Output pipeline register. Anything other than an accepted instruction
    // (flush or empty input) drains the stage, except a stall which holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_o  <= 1'b0;
            CondEx   <= 1'b0;
            PCSrc    <= 1'b0;
            RegWrite <= 1'b0;
            MemWrite <= 1'b0;
        end else if (!stall_i) begin
            if (accept) begin
                valid_o  <= 1'b1;
                CondEx   <= condExC;
                PCSrc    <= PCS  & condExC;
                RegWrite <= RegW & condExC;
                MemWrite <= MemW & condExC;
            end else begin
                valid_o  <= 1'b0;
                CondEx   <= 1'b0;
                PCSrc    <= 1'b0;
                RegWrite <= 1'b0;
                MemWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

    localparam bit ALLOW_NV_TB = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic       stall_i;
    logic       flush_i;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       valid_o;
    logic       CondEx;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

    // {valid_o, CondEx, PCSrc, RegWrite, MemWrite, Flags}
    typedef struct {
        string      tag;
        logic [8:0] outs;
    } exp_t;

    exp_t expQ[$];
    exp_t lastExp;
    int   nVec  = 0;
    int   nFail = 0;

    logic [15:0] condMask[16];

    always #5 clk = ~clk;

    cond_unit #(
        .RESET_FLAGS(4'b0000),
        .ALLOW_NV   (ALLOW_NV_TB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .Cond    (Cond),
        .ALUFlags(ALUFlags),
        .FlagW   (FlagW),
        .PCS     (PCS),
        .RegW    (RegW),
        .MemW    (MemW),
        .valid_o (valid_o),
        .CondEx  (CondEx),
        .PCSrc   (PCSrc),
        .RegWrite(RegWrite),
        .MemWrite(MemWrite),
        .Flags   (Flags)
    );

    // Inputs change on the falling edge; the expectation is what the outputs
    // must show after the following rising edge.
    task automatic drive(input string tag, input logic rst, input logic v,
                         input logic st, input logic fl, input logic [3:0] c,
                         input logic [3:0] af, input logic [1:0] fw,
                         input logic p, input logic rw, input logic mw,
                         input logic [8:0] e);
        exp_t x;
        @(negedge clk);
        reset    = rst;
        valid_i  = v;
        stall_i  = st;
        flush_i  = fl;
        Cond     = c;
        ALUFlags = af;
        FlagW    = fw;
        PCS      = p;
        RegW     = rw;
        MemW     = mw;
        x.tag    = tag;
        x.outs   = e;
        expQ.push_back(x);
        lastExp  = x;
    endtask

    function automatic logic [8:0] mk(input logic v, input logic ce, input logic pc,
                                      input logic rw, input logic mw, input logic [3:0] f);
        return {v, ce, pc, rw, mw, f};
    endfunction

    // Monitor: one comparison per rising edge that has a pending expectation.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                exp_t x;
                logic [8:0] got;
                x   = expQ.pop_front();
                got = {valid_o, CondEx, PCSrc, RegWrite, MemWrite, Flags};
                nVec++;
                if (got !== x.outs) begin
                    nFail++;
                    $display("FAIL %s: got v/ce/pc/rw/mw/flags=%b required %b", x.tag, got, x.outs);
                end
                $display("vec %0d %s: v=%b ce=%b pc=%b rw=%b mw=%b flags=%b", nVec, x.tag,
                         got[8], got[7], got[6], got[5], got[4], got[3:0]);
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic        ce;
        logic [15:0] m;
        condMask[0]  = 16'hF0F0;  // EQ
        condMask[1]  = 16'h0F0F;  // NE
        condMask[2]  = 16'hCCCC;  // CS
        condMask[3]  = 16'h3333;  // CC
        condMask[4]  = 16'hFF00;  // MI
        condMask[5]  = 16'h00FF;  // PL
        condMask[6]  = 16'hAAAA;  // VS
        condMask[7]  = 16'h5555;  // VC
        condMask[8]  = 16'h0C0C;  // HI
        condMask[9]  = 16'hF3F3;  // LS
        condMask[10] = 16'hAA55;  // GE
        condMask[11] = 16'h55AA;  // LT
        condMask[12] = 16'h0A05;  // GT
        condMask[13] = 16'hF5FA;  // LE
        condMask[14] = 16'hFFFF;  // AL
        condMask[15] = ALLOW_NV_TB ? 16'hFFFF : 16'h0000;  // NV

        reset = 1'b0; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            r = $urandom;
            drive("reset", 1'b0, r[0], r[1], r[2], r[7:4], r[11:8], r[13:12],
                  r[14], r[15], r[16], mk(0, 0, 0, 0, 0, 4'b0000));
        end

        // AL with full flag write, then EQ sees the new Z back-to-back
        drive("al_regw", 1, 1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 1, 0, mk(1, 1, 0, 1, 0, 4'b0100));
        drive("eq_memw", 1, 1, 0, 0, 4'h0, 4'b0000, 2'b00, 0, 0, 1, mk(1, 1, 0, 0, 1, 4'b0100));
        // NE fails: no PC write, no flag update
        drive("ne_skip", 1, 1, 0, 0, 4'h1, 4'b1000, 2'b11, 1, 0, 0, mk(1, 0, 0, 0, 0, 4'b0100));

        // Split flag enables
        drive("al_zero", 1, 1, 0, 0, 4'hE, 4'b0000, 2'b11, 0, 0, 0, mk(1, 1, 0, 0, 0, 4'b0000));
        drive("cv_only", 1, 1, 0, 0, 4'hE, 4'b1111, 2'b01, 0, 0, 0, mk(1, 1, 0, 0, 0, 4'b0011));
        drive("nz_only", 1, 1, 0, 0, 4'hE, 4'b1100, 2'b10, 0, 0, 0, mk(1, 1, 0, 0, 0, 4'b1111));

        // Full sweep: set flags with AL, then test each condition
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                drive("sweep_set", 1, 1, 0, 0, 4'hE, 4'(f), 2'b11, 0, 0, 0,
                      mk(1, 1, 0, 0, 0, 4'(f)));
                m  = condMask[c];
                ce = m[f];
                drive($sformatf("sweep_c%0d_f%0d", c, f), 1, 1, 0, 0, 4'(c), 4'b0000, 2'b00,
                      0, 1, 0, mk(1, ce, 0, ce, 0, 4'(f)));
            end
        end

        // Stall holds outputs and flags, also with flush asserted
        drive("live", 1, 1, 0, 0, 4'hE, 4'b0010, 2'b11, 0, 1, 0, mk(1, 1, 0, 1, 0, 4'b0010));
        drive("stall1", 1, 1, 1, 0, 4'hE, 4'b1111, 2'b11, 1, 0, 1, lastExp.outs);
        drive("stall2", 1, 1, 1, 1, 4'h0, 4'b1001, 2'b11, 1, 1, 1, lastExp.outs);
        drive("stall3", 1, 0, 1, 0, 4'hE, 4'b0101, 2'b11, 0, 0, 1, lastExp.outs);
        drive("release", 1, 1, 0, 0, 4'h2, 4'b0000, 2'b00, 1, 0, 0, mk(1, 1, 1, 0, 0, 4'b0010));

        // Flush and empty input
        drive("flush", 1, 1, 0, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, mk(0, 0, 0, 0, 0, 4'b0010));
        drive("live2", 1, 1, 0, 0, 4'hE, 4'b0010, 2'b00, 0, 1, 0, mk(1, 1, 0, 1, 0, 4'b0010));
        drive("empty", 1, 0, 0, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, mk(0, 0, 0, 0, 0, 4'b0010));

        // Reset during stall clears everything
        drive("live3", 1, 1, 0, 0, 4'hE, 4'b1010, 2'b11, 1, 0, 1, mk(1, 1, 1, 0, 1, 4'b1010));
        drive("stall_hold", 1, 1, 1, 0, 4'h0, 4'b0000, 2'b11, 0, 0, 0, lastExp.outs);
        drive("stall_reset", 0, 1, 1, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, mk(0, 0, 0, 0, 0, 4'b0000));
        drive("post_reset", 1, 0, 1, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, mk(0, 0, 0, 0, 0, 4'b0000));

        // Drain with a bounded wait
        for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL drain: %0d expectations pending, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
